// File: rtl/hdmi_audio_buf.sv
// hdmi_audio_buf: stereo PCM FIFO plus 32 kHz pacer feeding the HDMI encoder.
// Samples arrive in bursts, are queued, and one pair is released per tick of
// a fractional accumulator identical to the encoder's own packet cadence.
`timescale 1ns/1ps
module hdmi_audio_buf #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TICK_ADD   = 4,
  parameter int TICK_LIMIT = 3375
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [15:0]           in_left,
  input  logic [15:0]           in_right,
  output logic                  in_ready,
  output logic [15:0]           SampleL,
  output logic [15:0]           SampleR,
  output logic                  sample_tick,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  output logic                  overrun,
  output logic                  dbg_run_o
);

  // Handshake: a pair transfers on any cycle with in_valid && in_ready.
  // in_valid while in_ready is low is not stalled: the pair is dropped and
  // overrun pulses the following cycle, so the source never has to hold data.

  localparam int                    DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LEVEL_HALF = (DEPTH_LOG2+1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
  localparam logic [11:0]           ACC_ADD    = 12'(TICK_ADD);
  localparam logic [11:0]           ACC_LIMIT  = 12'(TICK_LIMIT);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Sample storage; contents are not reset.
  logic [15:0] mem_l [DEPTH];
  logic [15:0] mem_r [DEPTH];

  logic [11:0]           acc_q,    acc_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q,  level_d;
  state_t                state_q;
  logic [15:0]           sample_l_q;
  logic [15:0]           sample_r_q;
  logic                  underrun_q;
  logic                  overrun_q;

  logic full;
  logic empty;
  logic tick;
  logic push;
  logic pop;

  // Event decode: what happens to the FIFO this cycle.
  always_comb begin
    full  = (level_q == LEVEL_FULL);
    empty = (level_q == '0);
    tick  = (acc_q >= ACC_LIMIT);
    push  = in_valid && !full;
    pop   = (state_q == S_RUN) && tick && !empty;
  end

  // Next-state values for accumulator, pointers and occupancy counter.
  always_comb begin
    acc_d    = tick ? (acc_q - ACC_LIMIT + ACC_ADD) : (acc_q + ACC_ADD);
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Datapath registers: tick accumulator, FIFO pointers and level.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // RAM write port; a dropped push never touches storage.
  always_ff @(posedge pixclk) begin
    if (push) begin
      mem_l[wr_ptr_q] <= in_left;
      mem_r[wr_ptr_q] <= in_right;
    end
  end

  // FILL/RUN controller with registered sample outputs and event pulses.
  // The FILL->RUN decision looks at the registered level, so a tick landing
  // on the transition cycle is ignored rather than popping early.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q    <= S_FILL;
      sample_l_q <= '0;
      sample_r_q <= '0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      overrun_q  <= in_valid && full;
      case (state_q)
        S_FILL: begin
          if (level_q >= LEVEL_HALF) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (empty) begin
              underrun_q <= 1'b1;
              state_q    <= S_FILL;
            end else begin
              sample_l_q <= mem_l[rd_ptr_q];
              sample_r_q <= mem_r[rd_ptr_q];
            end
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready    = !reset && !full;
  assign SampleL     = sample_l_q;
  assign SampleR     = sample_r_q;
  assign sample_tick = tick;
  assign level       = level_q;
  assign underrun    = underrun_q;
  assign overrun     = overrun_q;
  assign dbg_run_o   = (state_q == S_RUN);

`ifndef SYNTHESIS
  // Occupancy must stay within depth and agree with the pointer distance.
  always_ff @(posedge pixclk) begin
    if (!reset) begin
      assert (level_q <= LEVEL_FULL)
        else $error("hdmi_audio_buf: level %0d above depth", level_q);
      assert ((wr_ptr_q - rd_ptr_q) == level_q[DEPTH_LOG2-1:0])
        else $error("hdmi_audio_buf: pointer distance disagrees with level");
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_audio_buf.sv
// tb_hdmi_audio_buf: per-cycle comparison against a queue-based model of the
// audio buffer, plus directed checks for the tick cadence and corner cases.
`timescale 1ns/1ps
module tb_hdmi_audio_buf;

  localparam int DEPTH    = 16;
  localparam int TB_ADD   = 4;
  localparam int TB_LIMIT = 3375;

  // ---------------- clock / reset / DUT ----------------
  logic        pixclk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_left;
  logic [15:0] in_right;
  logic        in_ready;
  logic [15:0] SampleL;
  logic [15:0] SampleR;
  logic        sample_tick;
  logic [4:0]  level;
  logic        underrun;
  logic        overrun;
  logic        dbg_run_o;

  always #5 pixclk = ~pixclk;

  hdmi_audio_buf #(
    .DEPTH_LOG2(4),
    .TICK_ADD  (TB_ADD),
    .TICK_LIMIT(TB_LIMIT)
  ) dut (
    .pixclk     (pixclk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_left    (in_left),
    .in_right   (in_right),
    .in_ready   (in_ready),
    .SampleL    (SampleL),
    .SampleR    (SampleR),
    .sample_tick(sample_tick),
    .level      (level),
    .underrun   (underrun),
    .overrun    (overrun),
    .dbg_run_o  (dbg_run_o)
  );

  // ---------------- scoreboard / model state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];     // queued {left, right} pairs
  logic        m_run = 1'b0;
  logic [15:0] m_l   = '0;
  logic [15:0] m_r   = '0;
  logic        m_ur  = 1'b0;
  logic        m_ov  = 1'b0;
  int          m_cyc = 0;    // cycles since reset release
  int          tick_log[$];  // release-relative cycles where the DUT ticked

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // 32 kHz tick k lands on the first cycle n where n*ADD reaches k*LIMIT.
  function automatic bit tick_at(input int n);
    if (n < 1) return 1'b0;
    return ((TB_ADD * n) / TB_LIMIT) != ((TB_ADD * (n - 1)) / TB_LIMIT);
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic rst, input logic v, input logic [15:0] l, input logic [15:0] r);
    bit t;
    bit was_full;
    bit do_pop;
    bit starve;
    int sz;
    reset    = rst;
    in_valid = v;
    in_left  = l;
    in_right = r;
    @(negedge pixclk);
    check("sample_l",  SampleL,     m_l);
    check("sample_r",  SampleR,     m_r);
    check("level",     level,       exp_q.size());
    check("tick",      sample_tick, tick_at(m_cyc));
    check("in_ready",  in_ready,    !rst && (exp_q.size() != DEPTH));
    check("underrun",  underrun,    m_ur);
    check("overrun",   overrun,     m_ov);
    check("run_state", dbg_run_o,   m_run);
    if (sample_tick === 1'b1) tick_log.push_back(m_cyc);
    if (rst) begin
      exp_q.delete();
      tick_log.delete();
      m_run = 1'b0;
      m_l   = '0;
      m_r   = '0;
      m_ur  = 1'b0;
      m_ov  = 1'b0;
      m_cyc = 0;
    end else begin
      sz       = exp_q.size();
      t        = tick_at(m_cyc);
      was_full = (sz == DEPTH);
      do_pop   = m_run && t && (sz > 0);
      starve   = m_run && t && (sz == 0);
      if (!m_run) m_run = (sz >= DEPTH / 2);
      else if (starve) m_run = 1'b0;
      if (do_pop) {m_l, m_r} = exp_q.pop_front();
      if (v && !was_full) exp_q.push_back({l, r});
      m_ov  = v && was_full;
      m_ur  = starve;
      m_cyc = m_cyc + 1;
    end
    @(posedge pixclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Advance until the model predicts a tick in the current cycle.
  task automatic run_to_tick();
    int n = 0;
    while (!tick_at(m_cyc) && n < 2000) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      n++;
    end
    if (!tick_at(m_cyc)) check("tick_wait_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int got;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_left  = '0;
    in_right = '0;
    @(posedge pixclk);
    #1;
    repeat (3) step(1'b1, 1'b0, 16'h0, 16'h0);

    // Idle after reset: nothing moves except the tick.
    idle(4000);
    check("idle_level", level, 0);
    check("idle_run", dbg_run_o, 0);
    check("idle_sample_l", SampleL, 0);
    for (int k = 0; k < 4; k++) begin
      got = (k < tick_log.size()) ? tick_log[k] : -1;
      check($sformatf("idle_tick%0d", k + 1), got, (TB_LIMIT * (k + 1) + TB_ADD - 1) / TB_ADD);
    end

    // Eight ascending pairs, then drain past empty.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 16'(i), 16'(i) ^ 16'hFFFF);
    check("fill8_level", level, 8);
    idle(1);
    check("fill8_run", dbg_run_o, 1);
    n = 0;
    while (!m_ur && n < 9000) begin
      idle(1);
      n++;
    end
    if (!m_ur) check("underrun_timeout", 32'd0, 32'd1);
    idle(1);
    check("hold_l", SampleL, 16'h0008);
    check("hold_r", SampleR, 16'hFFF7);
    check("back_to_fill", dbg_run_o, 0);

    // Twenty pushes between ticks: saturate, drop the last four.
    run_to_tick();
    idle(1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    check("full_level", level, 16);
    check("full_ready", in_ready, 0);

    // Push while full on a tick cycle: dropped, but the pop still happens.
    run_to_tick();
    step(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    check("tick_full_level", level, 15);
    check("tick_full_overrun", overrun, 1);

    // Reset in RUN with five pairs queued.
    n = 0;
    while (exp_q.size() != 5 && n < 12000) begin
      idle(1);
      n++;
    end
    check("pre_reset_level", level, 5);
    check("pre_reset_run", dbg_run_o, 1);
    step(1'b1, 1'b0, 16'h0, 16'h0);
    check("rst_level", level, 0);
    check("rst_sample_l", SampleL, 0);
    check("rst_sample_r", SampleR, 0);
    n = 0;
    while (tick_log.size() == 0 && n < 1000) begin
      idle(1);
      n++;
    end
    got = (tick_log.size() > 0) ? tick_log[0] : -1;
    check("first_tick_after_reset", got, 844);

    // Bursty random traffic, with one mid-stream reset.
    for (int seg = 0; seg < 10; seg++) begin
      int p;
      p = (seg % 3 == 2) ? 400 : $urandom_range(0, 3);
      if (seg == 7) step(1'b1, 1'b0, 16'h0, 16'h0);
      for (int i = 0; i < 1500; i++) begin
        step(1'b0, ($urandom_range(0, 999) < p), 16'($urandom), 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
